impulse_accumulator: RTL
========================

# impulse_accumulator

Sums per-body contact impulses produced by the contact solver over one physics frame. Once the solver signals completion, it drains one combined impulse record per body, in index order, to the OBB update stage. Each record carries linear impulse, rotational impulse, positional nudge and an impulse-enable flag. The block sits between the contact solver (upstream) and the per-body OBB updater (downstream).

## Interface
- `NUM_BODIES`, 8: number of tracked bodies. Power of two, 2..32.
- `IDX_W`, $clog2(NUM_BODIES): body index width.
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: pulse; opens an accumulation frame.
- `solve_done` in 1: pulse; the solver has issued all contacts for the frame.
- `in_valid` in 1: contact impulse valid.
- `in_ready` out 1: accumulator can accept a contact.
- `in_idx` in IDX_W: target body.
- `in_imp_x`, `in_imp_y` in 24 each: linear impulse, signed Q5.19.
- `in_rot` in 24: rotational impulse, signed Q5.19.
- `in_nudge_x`, `in_nudge_y` in 24 each: positional correction, signed Q8.16.
- `out_valid` out 1: drained record valid.
- `out_ready` in 1: downstream accepts the record.
- `out_idx` out IDX_W: body the record belongs to.
- `out_imp_x`, `out_imp_y`, `out_rot`, `out_nudge_x`, `out_nudge_y` out: same widths and formats as the inputs.
- `out_impulse_en` out 1: the body received at least one contact this frame.
- `frame_done` out 1: one-cycle pulse after the last record is accepted.

## Operation
- Storage: one flop-based entry per body, holding five 24-bit sums and a `hit` bit. No RAM.
- FSM states and transitions:
  - IDLE → ACCUM on `frame_start`.
  - ACCUM → DRAIN on `solve_done`.
  - DRAIN → DONE after the `out_valid && out_ready` handshake for index NUM_BODIES-1.
  - DONE → IDLE unconditionally.
- `frame_start` outside IDLE and `solve_done` outside ACCUM are ignored.
- ACCUM:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, each field of `entry[in_idx]` becomes entry + input, and `hit` is set.
  - Back-to-back contacts to the same body accumulate correctly. There are no read-modify-write hazards because the read is combinational.
- Same-cycle `in_valid` and `solve_done`: the contact is accepted and included in the drain.
- DRAIN:
  - `in_ready` = 0.
  - A drain counter starts at 0.
  - `out_*` present `entry[counter]`, and `out_impulse_en` = `hit`.
  - On handshake, that entry is cleared to zero and `hit` is cleared, then the counter increments.
  - Every body is emitted, including those with `hit` = 0 and zero sums.
- Entering ACCUM also clears all entries, so a frame never inherits stale sums.
- Arithmetic:
  - Each addition is 24-bit two's-complement.
  - Overflow handling is set by the macro described under Configuration.
  - Formats are unchanged by the addition; no rescaling.

## Timing
- Reset values:
  - `in_ready` = 0, `out_valid` = 0, `frame_done` = 0.
  - All `out_*` data = 0, `out_idx` = 0.
  - All entries and `hit` bits = 0, counter = 0, state = IDLE.
- `in_ready` rises in the cycle after `frame_start` is sampled.
- An accepted contact is visible in the entry on the next clock edge.
- Latency from `solve_done` sampled to `out_valid` high: 1 cycle.
- Drain handshake rules:
  - While `out_valid` is high and `out_ready` is low, all `out_*` signals hold stable.
  - With `out_ready` tied high, the drain is exactly NUM_BODIES consecutive cycles.
- `frame_done` is high for the single DONE cycle, one cycle after the final handshake.
- `out_valid` is 0 in DONE.
- An asynchronous `rst_n` assertion at any point, including mid-drain, immediately forces all reset values. The partially drained frame is discarded.

## Configuration
- `IMPULSE_ACC_SAT_EN` defined: each sum saturates at 24'h7FFFFF or 24'h800000 on signed overflow.
- Not defined: sums wrap modulo 2^24.
- The macro affects only the adder. Interface and timing are identical in both builds.

## Structure
- Shared package `phys_pkg` holds:
  - `IMP_W` = 24, `IMP_FRAC` = 19, `NUDGE_FRAC` = 16.
  - Typedef `impulse_t` (struct of the five signed fields).
  - Enum `acc_state_e` {IDLE, ACCUM, DRAIN, DONE}.
- Sub-module `sat_add24`: signed 24-bit adder honouring `IMPULSE_ACC_SAT_EN`. Instantiated five times on the write path.

## Test plan
- **Single contact:** frame_start; one contact to idx 2 with imp_x = 24'h080000 (+1.0), then solve_done, out_ready = 1. Expect 8 records. Idx 2 has imp_x = 24'h080000 and impulse_en = 1; all others are zero with impulse_en = 0. frame_done fires 1 cycle after idx 7.
- **Same-body accumulation:** back-to-back contacts to idx 5 with rot = +1.5 (24'h0C0000) and -0.5 (24'hFC0000). Expect drained rot = 24'h080000.
- **Overflow:** two contacts to idx 0 with imp_y = +10.0 (24'h500000).
  - With `IMPULSE_ACC_SAT_EN`: expect 24'h7FFFFF.
  - Without: expect 24'hA00000.
- **Backpressure:** out_ready low for 5 cycles while idx 3 is presented. Expect out_idx = 3 and all data stable for 5 cycles. Idx 3 is consumed once out_ready rises.
- **Simultaneous input and completion:** in_valid to idx 1 (nudge_x = 24'h010000) in the same cycle as solve_done. Expect the idx 1 record to show nudge_x = 24'h010000.
- **Reset mid-drain:** deassert rst_n after 3 handshakes. Expect all outputs at reset values immediately. A following frame with no contacts drains all zeros.

Source files
------------

// File: rtl/phys_pkg.sv
// ---------------------------------------------------------------------------
// phys_pkg
// Shared types and constants for the physics contact pipeline.
//   IMP_W      : width of every impulse / nudge word (24 bits)
//   IMP_FRAC   : fraction bits of linear and rotational impulses (Q5.19)
//   NUDGE_FRAC : fraction bits of positional nudges (Q8.16)
//   impulse_t  : packed record of the five signed per-body sums
//   acc_state_e: impulse_accumulator FSM states
// ---------------------------------------------------------------------------
package phys_pkg;

  localparam int IMP_W      = 24;
  localparam int IMP_FRAC   = 19;
  localparam int NUDGE_FRAC = 16;

  typedef logic signed [IMP_W-1:0] imp_word_t;

  // Field order is significant: concatenations elsewhere pack and unpack the
  // record as {imp_x, imp_y, rot, nudge_x, nudge_y}, imp_x in the MSBs.
  typedef struct packed {
    imp_word_t imp_x;
    imp_word_t imp_y;
    imp_word_t rot;
    imp_word_t nudge_x;
    imp_word_t nudge_y;
  } impulse_t;

  localparam impulse_t IMPULSE_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } acc_state_e;

endpackage : phys_pkg

// File: rtl/sat_add24.sv
// ---------------------------------------------------------------------------
// sat_add24
// Signed 24-bit two's-complement adder used on the accumulator write path.
// Build option (macro IMPULSE_ACC_SAT_EN):
//   defined     : on signed overflow the sum clamps to 24'h7FFFFF / 24'h800000
//   not defined : the sum wraps modulo 2^24
// Ports:
//   a, b : addends (signed, any fixed-point format; format is preserved)
//   sum  : result, same width and format as the addends
// ---------------------------------------------------------------------------
module sat_add24
  import phys_pkg::*;
(
  input  logic signed [IMP_W-1:0] a,
  input  logic signed [IMP_W-1:0] b,
  output logic signed [IMP_W-1:0] sum
);

`ifdef IMPULSE_ACC_SAT_EN
  // One guard bit: when the two top bits of the widened sum disagree the
  // true result does not fit in IMP_W bits, and the guard bit is its sign.
  logic signed [IMP_W:0] wide;

  assign wide = {a[IMP_W-1], a} + {b[IMP_W-1], b};

  always_comb begin
    sum = wide[IMP_W-1:0];
    if (wide[IMP_W] != wide[IMP_W-1]) begin
      if (wide[IMP_W]) begin
        sum = {1'b1, {(IMP_W-1){1'b0}}};
      end else begin
        sum = {1'b0, {(IMP_W-1){1'b1}}};
      end
    end
  end
`else
  assign sum = a + b;
`endif

endmodule : sat_add24

// File: rtl/impulse_accumulator.sv
// ---------------------------------------------------------------------------
// impulse_accumulator
// Sums per-body contact impulses over one physics frame, then drains one
// combined record per body, in index order, to the OBB update stage.
//
// Build option: IMPULSE_ACC_SAT_EN selects saturating sums (see sat_add24);
// without it sums wrap modulo 2^24. Interface and timing are identical.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   frame_start         : pulse, opens a frame (honoured only in IDLE)
//   solve_done          : pulse, all contacts issued (honoured only in ACCUM)
//   in_valid/in_ready   : contact handshake; in_ready is high only in ACCUM
//   in_idx              : target body of the contact
//   in_imp_x/_y, in_rot : linear / rotational impulse, signed Q5.19
//   in_nudge_x/_y       : positional correction, signed Q8.16
//   out_valid/out_ready : drained-record handshake; out_valid only in DRAIN
//   out_idx             : body of the presented record
//   out_imp_x .. out_nudge_y : summed fields, same formats as the inputs
//   out_impulse_en      : the body received at least one contact this frame
//   frame_done          : one-cycle pulse after the last record is taken
//   dbg_state           : current FSM state, for observation only
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds valid and its data
// stable until that edge; ready may change freely. Neither side waits on the
// other combinationally.
// ---------------------------------------------------------------------------
module impulse_accumulator
  import phys_pkg::*;
#(
  parameter int NUM_BODIES = 8,
  parameter int IDX_W      = $clog2(NUM_BODIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             solve_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [IMP_W-1:0] in_imp_x,
  input  logic [IMP_W-1:0] in_imp_y,
  input  logic [IMP_W-1:0] in_rot,
  input  logic [IMP_W-1:0] in_nudge_x,
  input  logic [IMP_W-1:0] in_nudge_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [IMP_W-1:0] out_imp_x,
  output logic [IMP_W-1:0] out_imp_y,
  output logic [IMP_W-1:0] out_rot,
  output logic [IMP_W-1:0] out_nudge_x,
  output logic [IMP_W-1:0] out_nudge_y,
  output logic             out_impulse_en,
  output logic             frame_done,
  output acc_state_e       dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BODIES - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  acc_state_e            state_q;
  logic [IDX_W-1:0]      cnt_q;
  impulse_t              entry_q [NUM_BODIES];
  logic [NUM_BODIES-1:0] hit_q;

  // -------------------------------------------------------------------------
  // Write path: the current sum is read combinationally, so consecutive
  // contacts to the same body always see the sum written by the previous
  // edge and need no forwarding.
  // -------------------------------------------------------------------------
  impulse_t  cur_entry;
  impulse_t  contact;
  impulse_t  sum_entry;
  imp_word_t sum_imp_x;
  imp_word_t sum_imp_y;
  imp_word_t sum_rot;
  imp_word_t sum_nudge_x;
  imp_word_t sum_nudge_y;

  assign cur_entry = entry_q[in_idx];
  assign contact   = {in_imp_x, in_imp_y, in_rot, in_nudge_x, in_nudge_y};

  sat_add24 u_add_imp_x (
    .a   (cur_entry.imp_x),
    .b   (contact.imp_x),
    .sum (sum_imp_x)
  );

  sat_add24 u_add_imp_y (
    .a   (cur_entry.imp_y),
    .b   (contact.imp_y),
    .sum (sum_imp_y)
  );

  sat_add24 u_add_rot (
    .a   (cur_entry.rot),
    .b   (contact.rot),
    .sum (sum_rot)
  );

  sat_add24 u_add_nudge_x (
    .a   (cur_entry.nudge_x),
    .b   (contact.nudge_x),
    .sum (sum_nudge_x)
  );

  sat_add24 u_add_nudge_y (
    .a   (cur_entry.nudge_y),
    .b   (contact.nudge_y),
    .sum (sum_nudge_y)
  );

  assign sum_entry = {sum_imp_x, sum_imp_y, sum_rot, sum_nudge_x, sum_nudge_y};

  // -------------------------------------------------------------------------
  // FSM, storage and handshake flags. in_ready, out_valid and frame_done are
  // flops set on the transition into the state they belong to, so they are
  // glitch-free and line up exactly with the state register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      hit_q      <= '0;
      for (int i = 0; i < NUM_BODIES; i++) begin
        entry_q[i] <= IMPULSE_ZERO;
      end
    end else begin
      case (state_q)
        IDLE: begin
          frame_done <= 1'b0;
          if (frame_start) begin
            state_q  <= ACCUM;
            in_ready <= 1'b1;
            // A new frame must never see sums left over from an aborted one.
            hit_q    <= '0;
            for (int i = 0; i < NUM_BODIES; i++) begin
              entry_q[i] <= IMPULSE_ZERO;
            end
          end
        end

        ACCUM: begin
          // A contact arriving together with solve_done is still accepted,
          // because in_ready is high for this whole cycle.
          if (in_valid && in_ready) begin
            entry_q[in_idx] <= sum_entry;
            hit_q[in_idx]   <= 1'b1;
          end
          if (solve_done) begin
            state_q   <= DRAIN;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            cnt_q     <= '0;
          end
        end

        DRAIN: begin
          if (out_valid && out_ready) begin
            entry_q[cnt_q] <= IMPULSE_ZERO;
            hit_q[cnt_q]   <= 1'b0;
            if (cnt_q == LAST_IDX) begin
              state_q    <= DONE;
              out_valid  <= 1'b0;
              frame_done <= 1'b1;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        DONE: begin
          frame_done <= 1'b0;
          state_q    <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Drain outputs: the counter selects a stored entry. The mux inputs only
  // change on a handshake, so data holds while out_ready is low. Data is
  // forced to zero whenever no record is offered.
  // -------------------------------------------------------------------------
  impulse_t drain_entry;

  assign drain_entry    = entry_q[cnt_q];
  assign out_idx        = cnt_q;
  assign out_imp_x      = out_valid ? drain_entry.imp_x   : '0;
  assign out_imp_y      = out_valid ? drain_entry.imp_y   : '0;
  assign out_rot        = out_valid ? drain_entry.rot     : '0;
  assign out_nudge_x    = out_valid ? drain_entry.nudge_x : '0;
  assign out_nudge_y    = out_valid ? drain_entry.nudge_y : '0;
  assign out_impulse_en = out_valid & hit_q[cnt_q];
  assign dbg_state      = state_q;

endmodule : impulse_accumulator
